// File: rtl/pq_sort_driver_if.sv
// Stream-in / stream-out / pq-port bundle for pq_sort_driver.
// master is the driver side; slave is the environment (source, sink and pq).
interface pq_sort_driver_if #(
  parameter int unsigned W = 32
);
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_last;
  logic         in_ready;

  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_last;
  logic         out_ready;

  logic         pq_enq_valid;
  logic [W-1:0] pq_enq_value;
  logic         pq_enq_ready;
  logic         pq_deq_req;
  logic [W-1:0] pq_deq_value;
  logic         pq_deq_valid;

  modport master (
    input  in_valid, in_data, in_last, out_ready,
           pq_enq_ready, pq_deq_value, pq_deq_valid,
    output in_ready, out_valid, out_data, out_last,
           pq_enq_valid, pq_enq_value, pq_deq_req
  );

  modport slave (
    output in_valid, in_data, in_last, out_ready,
           pq_enq_ready, pq_deq_value, pq_deq_valid,
    input  in_ready, out_valid, out_data, out_last,
           pq_enq_valid, pq_enq_value, pq_deq_req
  );
endinterface

// File: rtl/pq_sort_driver.sv
// Batch sorter front-end: loads one input batch into a pq, then drains it
// largest-first onto the output stream, pacing pq requests with settle gaps.
module pq_sort_driver #(
  parameter int unsigned L      = 3,
  parameter int unsigned W      = 32,
  parameter int unsigned SETTLE = L
) (
  input  logic            clk,
  input  logic            rst,
  pq_sort_driver_if.master bus,
  output logic            trunc,
  output logic            busy
);

  localparam int unsigned CAP         = (1 << L) - 1;
  localparam int unsigned CW          = $clog2(CAP + 1);
  localparam int unsigned SW          = (SETTLE < 2) ? 1 : $clog2(SETTLE);
  localparam int unsigned SETTLE_LAST = (SETTLE == 0) ? 0 : SETTLE - 1;

  typedef enum logic [1:0] {
    ST_FILL   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_REQ    = 2'd2,
    ST_OUT    = 2'd3
  } state_e;

  state_e         state_q,     state_d;
  logic [CW-1:0]  cnt_q,       cnt_d;
  logic [SW-1:0]  settle_q,    settle_d;
  logic           trunc_q,     trunc_d;
  logic           busy_q,      busy_d;
  logic           deq_req_q,   deq_req_d;
  logic           out_valid_q, out_valid_d;
  logic [W-1:0]   out_data_q,  out_data_d;
  logic           out_last_q,  out_last_d;

  logic           in_ready_c;
  logic           enq_valid_c;
  logic [W-1:0]   enq_value_c;
  logic           in_xfer_c;
  logic           at_cap_m1_c;

  // State and registered outputs; reset clears everything at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_FILL;
      cnt_q       <= '0;
      settle_q    <= '0;
      trunc_q     <= 1'b0;
      busy_q      <= 1'b0;
      deq_req_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      settle_q    <= settle_d;
      trunc_q     <= trunc_d;
      busy_q      <= busy_d;
      deq_req_q   <= deq_req_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

  assign in_xfer_c   = (state_q == ST_FILL) && bus.in_valid && bus.pq_enq_ready;
  assign at_cap_m1_c = (cnt_q == CW'(CAP - 1));

  // Next-state and handshake decode.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    settle_d    = settle_q;
    trunc_d     = trunc_q;
    deq_req_d   = deq_req_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    in_ready_c  = 1'b0;
    enq_valid_c = 1'b0;
    enq_value_c = '0;

    unique case (state_q)
      ST_FILL: begin
        in_ready_c  = bus.pq_enq_ready;
        enq_valid_c = bus.in_valid;
        enq_value_c = bus.in_data;
        if (in_xfer_c) begin
          cnt_d = cnt_q + CW'(1);
          if (bus.in_last || at_cap_m1_c) begin
            state_d  = ST_SETTLE;
            settle_d = '0;
            trunc_d  = at_cap_m1_c && !bus.in_last;
          end
        end
      end

      ST_SETTLE: begin
        if (settle_q == SW'(SETTLE_LAST)) begin
          settle_d = '0;
          // An empty pq is never dequeued; fall back to FILL instead.
          if (cnt_q != '0) begin
            state_d   = ST_REQ;
            deq_req_d = 1'b1;
          end else begin
            state_d = ST_FILL;
            trunc_d = 1'b0;
          end
        end else begin
          settle_d = settle_q + SW'(1);
        end
      end

      ST_REQ: begin
        if (bus.pq_deq_valid) begin
          deq_req_d   = 1'b0;
          out_data_d  = bus.pq_deq_value;
          out_valid_d = 1'b1;
          out_last_d  = (cnt_q == CW'(1));
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
          end
          state_d = ST_OUT;
        end
      end

      ST_OUT: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          settle_d    = '0;
          if (cnt_q == '0) begin
            state_d    = ST_FILL;
            out_last_d = 1'b0;
            trunc_d    = 1'b0;
          end else begin
            state_d = ST_SETTLE;
          end
        end
      end

      default: begin
        state_d = ST_FILL;
      end
    endcase
  end

  assign busy_d = (state_d != ST_FILL);

  assign bus.in_ready     = in_ready_c;
  assign bus.pq_enq_valid = enq_valid_c;
  assign bus.pq_enq_value = enq_value_c;
  assign bus.pq_deq_req   = deq_req_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_data     = out_data_q;
  assign bus.out_last     = out_last_q;
  assign trunc            = trunc_q;
  assign busy             = busy_q;

endmodule

// File: tb/tb_pq_sort_driver.sv
// Bench for pq_sort_driver with a behavioural pq, a scoreboard queue of
// hand-computed sorted outputs and a monitor that checks every output beat.
module tb_pq_sort_driver;

  localparam int unsigned W   = 32;
  localparam int unsigned CAP = 7;

  typedef struct packed {
    logic         trunc;
    logic         last;
    logic [W-1:0] data;
  } exp_t;

  logic clk;
  logic rst;
  logic trunc;
  logic busy;

  pq_sort_driver_if #(.W(W)) bus ();

  pq_sort_driver #(.L(3), .W(W), .SETTLE(3)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .trunc (trunc),
    .busy  (busy)
  );

  int   n_checks;
  int   n_fail;
  exp_t exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Behavioural pq: fixed response latency, one answer per held request.
  logic [W-1:0] pq_mem[$];
  int           pq_cnt;
  logic         pq_pend;
  int           pq_lat;

  assign bus.pq_enq_ready = !rst && (pq_cnt < CAP);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pq_mem.delete();
      pq_cnt           <= 0;
      pq_pend          <= 1'b0;
      pq_lat           <= 0;
      bus.pq_deq_valid <= 1'b0;
      bus.pq_deq_value <= '0;
    end else begin
      bus.pq_deq_valid <= 1'b0;
      if (bus.pq_enq_valid && bus.pq_enq_ready && !bus.pq_deq_req) begin
        pq_mem.push_back(bus.pq_enq_value);
        pq_cnt <= pq_cnt + 1;
      end
      if (pq_pend) begin
        if (pq_lat == 0) begin
          int           mi;
          logic [W-1:0] mv;
          mi = 0;
          mv = pq_mem[0];
          for (int i = 1; i < pq_mem.size(); i++) begin
            if (pq_mem[i] > mv) begin
              mv = pq_mem[i];
              mi = i;
            end
          end
          pq_mem.delete(mi);
          pq_cnt           <= pq_cnt - 1;
          bus.pq_deq_value <= mv;
          bus.pq_deq_valid <= 1'b1;
          pq_pend          <= 1'b0;
        end else begin
          pq_lat <= pq_lat - 1;
        end
      end else if (bus.pq_deq_req && !bus.pq_deq_valid) begin
        n_checks++;
        if (pq_mem.size() == 0) begin
          n_fail++;
          $display("FAIL deq_on_empty: got request with 0 entries, expected none (t=%0t)", $time);
        end else begin
          pq_pend <= 1'b1;
          pq_lat  <= 2;
        end
      end
    end
  end

  // Monitor: interface invariants every cycle, scoreboard on every output beat.
  always @(negedge clk) begin
    if (!rst) begin
      chk("no_enq_and_deq", W'(bus.pq_enq_valid && bus.pq_deq_req), W'(0));
      if (busy) begin
        chk("in_ready_busy", W'(bus.in_ready), W'(0));
        chk("enq_valid_busy", W'(bus.pq_enq_valid), W'(0));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_out: got %0h, expected no output (t=%0t)", bus.out_data, $time);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("out_data", bus.out_data, e.data);
          chk("out_last", W'(bus.out_last), W'(e.last));
          chk("trunc", W'(trunc), W'(e.trunc));
        end
      end
    end
  end

  task automatic exp_push(input logic [W-1:0] d, input logic last, input logic tr);
    exp_t e;
    e.data  = d;
    e.last  = last;
    e.trunc = tr;
    exp_q.push_back(e);
  endtask

  task automatic send(input logic [W-1:0] d, input logic last);
    int n;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    n = 0;
    while (!bus.in_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: got in_ready=0 for %0d cycles, expected acceptance of %0h", n, d);
    end else begin
      @(posedge clk);
    end
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (n >= 3000) begin
      n_fail++;
      $display("FAIL %s: got %0d beats pending, busy=%0b, expected drained and idle", name, exp_q.size(), busy);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_out_valid"}, W'(bus.out_valid), W'(0));
    chk({tag, "_out_data"}, bus.out_data, W'(0));
    chk({tag, "_out_last"}, W'(bus.out_last), W'(0));
    chk({tag, "_deq_req"}, W'(bus.pq_deq_req), W'(0));
    chk({tag, "_enq_valid"}, W'(bus.pq_enq_valid), W'(0));
    chk({tag, "_in_ready"}, W'(bus.in_ready), W'(0));
    chk({tag, "_trunc"}, W'(trunc), W'(0));
    chk({tag, "_busy"}, W'(busy), W'(0));
  endtask

  initial begin
    int n;
    n_checks      = 0;
    n_fail        = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;

    // Three-element batch, strictly descending output.
    exp_push(32'h444, 1'b0, 1'b0);
    exp_push(32'h44, 1'b0, 1'b0);
    exp_push(32'h4, 1'b1, 1'b0);
    send(32'h4, 1'b0);
    send(32'h44, 1'b0);
    send(32'h444, 1'b1);
    wait_idle("t1_idle");

    // Capacity cut: 1..7 without last, then 8 stalls and forms its own batch.
    for (int i = 7; i >= 1; i--) exp_push(W'(i), (i == 1), 1'b1);
    exp_push(32'h8, 1'b1, 1'b0);
    for (int i = 1; i <= 7; i++) send(W'(i), 1'b0);
    @(negedge clk);
    chk("t2_busy_after_cap", W'(busy), W'(1));
    chk("t2_in_ready_after_cap", W'(bus.in_ready), W'(0));
    send(32'h8, 1'b1);
    wait_idle("t2_idle");

    // Single-element batch.
    exp_push(32'h5, 1'b1, 1'b0);
    send(32'h5, 1'b1);
    wait_idle("t3_idle");
    @(negedge clk);
    chk("t3_busy_after", W'(busy), W'(0));

    // Backpressure on the first output beat.
    bus.out_ready = 1'b0;
    exp_push(32'h3, 1'b0, 1'b0);
    exp_push(32'h2, 1'b0, 1'b0);
    exp_push(32'h1, 1'b1, 1'b0);
    send(32'h3, 1'b0);
    send(32'h1, 1'b0);
    send(32'h2, 1'b1);
    n = 0;
    while (!bus.out_valid && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("t4_out_valid_seen", W'(bus.out_valid), W'(1));
    for (int i = 0; i < 10; i++) begin
      chk("t4_hold_data", bus.out_data, W'(3));
      chk("t4_hold_valid", W'(bus.out_valid), W'(1));
      chk("t4_hold_deq_req", W'(bus.pq_deq_req), W'(0));
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    wait_idle("t4_idle");

    // Duplicate values.
    exp_push(32'h9, 1'b0, 1'b0);
    exp_push(32'h9, 1'b0, 1'b0);
    exp_push(32'h3, 1'b1, 1'b0);
    send(32'h9, 1'b0);
    send(32'h9, 1'b0);
    send(32'h3, 1'b1);
    wait_idle("t5_idle");

    // Asynchronous reset while a dequeue request is outstanding.
    send(32'h10, 1'b0);
    send(32'h20, 1'b1);
    n = 0;
    while (!bus.pq_deq_req && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("t6_deq_req_seen", W'(bus.pq_deq_req), W'(1));
    #2;
    rst = 1'b1;
    #1;
    exp_q.delete();
    chk_all_zero("t6_rst");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_push(32'h7, 1'b1, 1'b0);
    send(32'h7, 1'b1);
    wait_idle("t6_idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no end of test by %0t, expected completion", $time);
    $fatal(1, "watchdog");
  end

endmodule
